// File: rtl/bnn_xnor_accum_if.sv
// Activation stream and result handshake between the activations stage,
// the XNOR accumulator and the writeback stage.
interface bnn_xnor_accum_if #(
    parameter int ROWS  = 32,
    parameter int WIDTH = 16,
    parameter int ACC_W = 16
);
    logic [ROWS*WIDTH-1:0] activation_in;
    logic [ROWS-1:0]       activation_in_valid;
    logic                  out_valid;
    logic                  out_ready;
    logic [ROWS-1:0]       out_bits;
    logic [ROWS*ACC_W-1:0] out_sums;
    logic                  done;

    modport master (
        output activation_in, activation_in_valid, out_ready,
        input  out_valid, out_bits, out_sums, done
    );

    modport slave (
        input  activation_in, activation_in_valid, out_ready,
        output out_valid, out_bits, out_sums, done
    );
endinterface

// File: rtl/bnn_xnor_accum.sv
// Per-row XNOR-popcount accumulator with stationary weights; binarizes each
// row sum against a threshold and hands the result over valid/ready.
module bnn_xnor_accum #(
    parameter int ROWS  = 32,
    parameter int WIDTH = 16,
    parameter int ACC_W = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 w_load,
    input  logic [4:0]           w_row,
    input  logic [WIDTH-1:0]     w_data,
    input  logic                 start,
    input  logic [10:0]          num_words,
    input  logic [ACC_W-1:0]     threshold,
    output logic                 busy,
    bnn_xnor_accum_if.slave      bus
);
    localparam int PC_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     weight  [ROWS];
    logic [ACC_W-1:0]     sum_q   [ROWS];
    logic [10:0]          count_q [ROWS];
    logic [10:0]          num_words_q;
    logic [ACC_W-1:0]     threshold_q;
    logic [ROWS-1:0]      out_bits_q;
    logic [ROWS*ACC_W-1:0] out_sums_q;
    logic                 done_q;
    logic                 all_done;

    function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) c = c + PC_W'(v[i]);
        return c;
    endfunction

    // Compare on the registered counts so the exit edge follows the final beat directly.
    always_comb begin
        all_done = 1'b1;
        for (int unsigned r = 0; r < ROWS; r++)
            if (count_q[r] != num_words_q) all_done = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (num_words != '0) ? ACCUM : OUTPUT;
            ACCUM:   if (all_done) state_d = OUTPUT;
            OUTPUT:  if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                weight[r]  <= '0;
                sum_q[r]   <= '0;
                count_q[r] <= '0;
            end
            num_words_q <= '0;
            threshold_q <= '0;
            out_bits_q  <= '0;
            out_sums_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (w_load && (32'(w_row) < ROWS)) weight[w_row] <= w_data;
                    if (start) begin
                        num_words_q <= num_words;
                        threshold_q <= threshold;
                        for (int unsigned r = 0; r < ROWS; r++) begin
                            sum_q[r]   <= '0;
                            count_q[r] <= '0;
                        end
                        // Empty pass skips ACCUM, so the zero result is registered here.
                        if (num_words == '0) begin
                            out_sums_q <= '0;
                            out_bits_q <= {ROWS{threshold == '0}};
                        end
                    end
                end
                ACCUM: begin
                    for (int unsigned r = 0; r < ROWS; r++) begin
                        if (bus.activation_in_valid[r] && (count_q[r] < num_words_q)) begin
                            sum_q[r]   <= sum_q[r] + ACC_W'(popcount(
                                ~(bus.activation_in[r*WIDTH +: WIDTH] ^ weight[r])));
                            count_q[r] <= count_q[r] + 11'd1;
                        end
                    end
                    if (all_done) begin
                        for (int unsigned r = 0; r < ROWS; r++) begin
                            out_sums_q[r*ACC_W +: ACC_W] <= sum_q[r];
                            out_bits_q[r]                <= (sum_q[r] >= threshold_q);
                        end
                    end
                end
                OUTPUT: if (bus.out_ready) done_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign busy          = (state_q != IDLE);
    assign bus.out_valid = (state_q == OUTPUT);
    assign bus.out_bits  = out_bits_q;
    assign bus.out_sums  = out_sums_q;
    assign bus.done      = done_q;
endmodule
